// File: rtl/wrb_port_arbiter.sv
// wrb_port_arbiter: shares the register-file write port between the pipeline and the divider.
// Divider results queue in a small FIFO; a starvation FSM stalls the pipeline so the FIFO can drain.
module wrb_port_arbiter #(
  parameter int DIV_BUF_DEPTH = 2,
  parameter int STARVE_LIMIT  = 4,
  parameter int RADDR_W       = 5,
  parameter int XLEN          = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pipe_wr_req_i,
  input  logic [RADDR_W-1:0] pipe_rd_addr_i,
  input  logic [XLEN-1:0]    pipe_rd_data_i,
  input  logic               div_valid_i,
  input  logic [RADDR_W-1:0] div_rd_addr_i,
  input  logic [XLEN-1:0]    div_data_i,
  output logic               div_ready_o,
  output logic               rf_wr_en_o,
  output logic [RADDR_W-1:0] rf_wr_addr_o,
  output logic [XLEN-1:0]    rf_wr_data_o,
  output logic               rf_wr_src_o,
  output logic               pipe_stall_o,
  input  logic [RADDR_W-1:0] lookup_rd_i,
  output logic               pend_hit_o
);

  localparam int AW = $clog2(DIV_BUF_DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic {NORMAL, FORCE} state_t;

  state_t state;
  state_t state_nxt;

  logic [RADDR_W-1:0] addr_mem [DIV_BUF_DEPTH];
  logic [XLEN-1:0]    data_mem [DIV_BUF_DEPTH];

  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_nxt;
  logic [SW-1:0] starve_cnt;
  logic [SW-1:0] starve_nxt;
  logic          ready_q;

  logic empty;
  logic full;
  logic div_acc;
  logic div_live;
  logic pipe_sel;
  logic fifo_sel;
  logic byp_sel;
  logic push;
  logic pop;
  logic pend_hit;

  assign empty     = (count == '0);
  assign full      = (count == CW'(DIV_BUF_DEPTH));
  assign div_acc   = div_valid_i & ready_q;
  assign div_live  = div_acc & (div_rd_addr_i != '0);
  assign pipe_sel  = pipe_wr_req_i & (pipe_rd_addr_i != '0);
  assign fifo_sel  = ~pipe_sel & ~empty;
  assign byp_sel   = ~pipe_sel & empty & div_live;
  assign pop       = fifo_sel;
  assign push      = div_live & ~byp_sel;
  assign count_nxt = count + CW'(push) - CW'(pop);

  assign div_ready_o = ready_q;

  // A non-empty FIFO that did not pop this cycle counts as blocked
  always_comb begin
    starve_nxt = starve_cnt;
    if (pop || empty)
      starve_nxt = '0;
    else if (starve_cnt < SW'(STARVE_LIMIT))
      starve_nxt = starve_cnt + SW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      starve_cnt <= '0;
      ready_q    <= 1'b0;
      for (int i = 0; i < DIV_BUF_DEPTH; i++) begin
        addr_mem[i] <= '0;
        data_mem[i] <= '0;
      end
    end else begin
      if (push) begin
        addr_mem[wr_ptr] <= div_rd_addr_i;
        data_mem[wr_ptr] <= div_data_i;
        wr_ptr           <= wr_ptr + AW'(1);
      end
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      count      <= count_nxt;
      starve_cnt <= starve_nxt;
      ready_q    <= (count_nxt < CW'(DIV_BUF_DEPTH));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= NORMAL;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      NORMAL:
        if ((starve_nxt >= SW'(STARVE_LIMIT)) ||
            (full && div_valid_i))
          state_nxt = FORCE;
      FORCE:
        if (count_nxt == '0)
          state_nxt = NORMAL;
    endcase
  end

  always_comb begin
    pipe_stall_o = (state == FORCE);
  end

  always_comb begin
    rf_wr_en_o   = 1'b0;
    rf_wr_addr_o = '0;
    rf_wr_data_o = '0;
    rf_wr_src_o  = 1'b0;
    unique case (1'b1)
      pipe_sel: begin
        rf_wr_en_o   = 1'b1;
        rf_wr_addr_o = pipe_rd_addr_i;
        rf_wr_data_o = pipe_rd_data_i;
      end
      fifo_sel: begin
        rf_wr_en_o   = 1'b1;
        rf_wr_addr_o = addr_mem[rd_ptr];
        rf_wr_data_o = data_mem[rd_ptr];
        rf_wr_src_o  = 1'b1;
      end
      byp_sel: begin
        rf_wr_en_o   = 1'b1;
        rf_wr_addr_o = div_rd_addr_i;
        rf_wr_data_o = div_data_i;
        rf_wr_src_o  = 1'b1;
      end
      default: ;
    endcase
  end

  // Queued entries plus an accepted result that is about to be queued
  always_comb begin
    pend_hit = push && (div_rd_addr_i == lookup_rd_i);
    for (int i = 0; i < DIV_BUF_DEPTH; i++)
      if ((CW'(i) < count) &&
          (addr_mem[rd_ptr + AW'(i)] == lookup_rd_i))
        pend_hit = 1'b1;
  end

  assign pend_hit_o = (lookup_rd_i != '0) & pend_hit;

endmodule
